// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
// Shared types for the registered bitwise logic unit:
//   op_e       - 3-bit operation select encoding
//   sk_state_e - occupancy state of the two-entry output skid buffer
// ---------------------------------------------------------------------------
package logic_unit_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_NOT  = 3'd4,
      OP_XOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      SK_EMPTY = 2'd0,
      SK_ONE   = 2'd1,
      SK_FULL  = 2'd2
   } sk_state_e;

endpackage

// File: rtl/lu_skid_buffer.sv
// ---------------------------------------------------------------------------
// lu_skid_buffer
// Two-entry output buffer (head + skid) with valid/ready on both sides.
// The head entry always drives out_data. in_ready is a register, so the
// producer never sees a combinational path from out_ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   in_data  [DW]       payload captured on accept
//   out_valid/out_ready downstream handshake
//   out_data [DW]       head-entry payload (zero while in reset)
// ---------------------------------------------------------------------------
module lu_skid_buffer
   import logic_unit_pkg::*;
#(
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   sk_state_e     state;
   sk_state_e     state_nxt;
   logic          rdy_p1;
   logic [DW-1:0] head_p1;
   logic [DW-1:0] skid_p1;
   logic          accept;
   logic          pop;
   logic          head_ld;
   logic          skid_ld;
   logic          skid_to_head;

   assign accept = in_valid && rdy_p1;
   assign pop    = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= SK_EMPTY;
         rdy_p1 <= 1'b1;
      end else begin
         state  <= state_nxt;
         // Ready is precomputed from the next state so it stays a flop output.
         rdy_p1 <= (state_nxt != SK_FULL);
      end
   end

   always_comb begin
      state_nxt    = state;
      head_ld      = 1'b0;
      skid_ld      = 1'b0;
      skid_to_head = 1'b0;
      case (state)
         SK_EMPTY: begin
            if (accept) begin
               state_nxt = SK_ONE;
               head_ld   = 1'b1;
            end
         end
         SK_ONE: begin
            if (accept && pop) begin
               head_ld   = 1'b1;
            end else if (accept) begin
               state_nxt = SK_FULL;
               skid_ld   = 1'b1;
            end else if (pop) begin
               state_nxt = SK_EMPTY;
            end
         end
         SK_FULL: begin
            if (pop) begin
               state_nxt    = SK_ONE;
               skid_to_head = 1'b1;
            end
         end
         default: state_nxt = SK_EMPTY;
      endcase
   end

   // ---- stage p1: buffered entries ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_p1 <= '0;
         skid_p1 <= '0;
      end else begin
         if (head_ld) begin
            head_p1 <= in_data;
         end else if (skid_to_head) begin
            head_p1 <= skid_p1;
         end
         if (skid_ld) begin
            skid_p1 <= in_data;
         end
      end
   end

   assign in_ready  = rdy_p1;
   assign out_valid = (state != SK_EMPTY);
   assign out_data  = head_p1;

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
// Registered WIDTH-bit bitwise logic unit (AND, OR, NAND, NOR, NOT, XOR,
// XNOR, PASS) with valid/ready handshakes and a two-entry output skid
// buffer: 1-cycle latency, 1 beat/cycle, registered in_ready.
// Optional build macro: LOGIC_UNIT_PIPE_PARITY_EN adds a_par, parity and
// the sticky par_err flag.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   a, b [WIDTH]        operands (b unused by NOT/PASS)
//   op [3]              operation select (logic_unit_pkg::op_e)
//   out_valid/out_ready result handshake
//   result [WIDTH]      bitwise result of head entry
//   zero, ones          result is all-zeros / all-ones
//   a_par (opt)         expected even-XOR parity of a
//   parity (opt)        XOR of result bits
//   par_err (opt)       sticky: an accepted a disagreed with a_par
// ---------------------------------------------------------------------------
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   input  logic             a_par,
   output logic             parity,
   output logic             par_err,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ones
);

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   localparam int PW = WIDTH + 3;
`else
   localparam int PW = WIDTH + 2;
`endif

   function automatic logic [WIDTH-1:0] lu_eval(input logic [OP_W-1:0] op_sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      r = x;
      case (op_e'(op_sel))
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_NAND: r = ~(x & y);
         OP_NOR:  r = ~(x | y);
         OP_NOT:  r = ~x;
         OP_XOR:  r = x ^ y;
         OP_XNOR: r = ~(x ^ y);
         OP_PASS: r = x;
         default: r = x;
      endcase
      return r;
   endfunction

   // ---- stage p0: combinational result and flags ----
   logic [WIDTH-1:0] res_p0;
   logic             zero_p0;
   logic             ones_p0;
   logic [PW-1:0]    pay_p0;
   logic [PW-1:0]    pay_p1;
   logic             vld_p1;

   assign res_p0  = lu_eval(op, a, b);
   assign zero_p0 = (res_p0 == '0);
   assign ones_p0 = &res_p0;

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   assign pay_p0 = {res_p0, zero_p0, ones_p0, ^res_p0};
`else
   assign pay_p0 = {res_p0, zero_p0, ones_p0};
`endif

   // ---- stage p1: skid buffer ----
   lu_skid_buffer #(
      .DW (PW)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (pay_p0),
      .out_valid (vld_p1),
      .out_ready (out_ready),
      .out_data  (pay_p1)
   );

   assign out_valid = vld_p1;

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   assign {result, zero, ones, parity} = pay_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err <= 1'b0;
      end else if (in_valid && in_ready && ((^a) != a_par)) begin
         par_err <= 1'b1;
      end
   end
`else
   assign {result, zero, ones} = pay_p1;
`endif

endmodule
